// File: rtl/ps2_dir_decoder.sv
// ps2_dir_decoder
//   Receives PS/2 keyboard frames in the clk_50 domain and translates
//   arrow keys (E0-prefixed) and WASD make codes into the 4-bit direction
//   code used by the game core: 0000 up, 0001 down, 0010 left,
//   0011 right, 1111 no move.  Also flags framing errors and timeouts
//   and reports the last good byte.
//
//   Parameters:
//     TIMEOUT_CYC - idle clk_50 cycles inside a frame before it is dropped
//     SYNC_STAGES - synchroniser depth for ps2_clk / ps2_data (>= 2)
//
//   Ports:
//     clk_50    in   system clock
//     rst_n     in   asynchronous active-low reset
//     ps2_clk   in   PS/2 clock pin (asynchronous)
//     ps2_data  in   PS/2 data pin (asynchronous)
//     kb        out  current direction code, held until changed
//     kb_valid  out  one-cycle pulse whenever kb is written
//     key_code  out  last byte received with good framing (incl. E0/F0)
//     frame_err out  one-cycle pulse on bad parity/stop or timeout
//
//   Optional feature: define PS2_DIR_RELEASE_CLEAR_EN so that releasing
//   the key whose direction is currently on kb returns kb to 1111.
module ps2_dir_decoder #(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] kb,
    output logic       kb_valid,
    output logic [7:0] key_code,
    output logic       frame_err
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q,    state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [2:0]             bit_cnt_q,  bit_cnt_d;
    logic [7:0]             shift_q,    shift_d;
    logic                   par_q,      par_d;
    logic [TW-1:0]          to_cnt_q,   to_cnt_d;
    logic                   ext_q,      ext_d;
    logic                   brk_q,      brk_d;
    logic [3:0]             kb_q,       kb_d;
    logic                   kb_valid_q, kb_valid_d;
    logic [7:0]             key_code_q, key_code_d;
    logic                   frame_err_q, frame_err_d;

    logic       fall;
    logic       sdata;
    logic       frame_good;
    logic       map_hit;
    logic [3:0] map_code;

    assign fall  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign sdata = dat_sync_q[SYNC_STAGES-1];

    // Evaluated only while sampling the stop bit, when shift_q/par_q are complete.
    assign frame_good = (^{shift_q, par_q}) & sdata;

    // Arrow keys only count with an E0 prefix; WASD only without one.
    always_comb begin
        map_hit  = 1'b0;
        map_code = 4'b1111;
        if (ext_q) begin
            case (shift_q)
                8'h75: begin map_hit = 1'b1; map_code = 4'b0000; end
                8'h72: begin map_hit = 1'b1; map_code = 4'b0001; end
                8'h6B: begin map_hit = 1'b1; map_code = 4'b0010; end
                8'h74: begin map_hit = 1'b1; map_code = 4'b0011; end
                default: ;
            endcase
        end else begin
            case (shift_q)
                8'h1D: begin map_hit = 1'b1; map_code = 4'b0000; end
                8'h1B: begin map_hit = 1'b1; map_code = 4'b0001; end
                8'h1C: begin map_hit = 1'b1; map_code = 4'b0010; end
                8'h23: begin map_hit = 1'b1; map_code = 4'b0011; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        to_cnt_d    = to_cnt_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        kb_d        = kb_q;
        kb_valid_d  = 1'b0;
        key_code_d  = key_code_q;
        frame_err_d = 1'b0;

        if (state_q == ST_IDLE) begin
            to_cnt_d = '0;
            if (fall && !sdata) begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
            end
        end else if (fall) begin
            to_cnt_d = '0;
            case (state_q)
                ST_DATA: begin
                    shift_d = {sdata, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
                ST_PARITY: begin
                    par_d   = sdata;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!frame_good) begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end else begin
                        key_code_d = shift_q;
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                            if (map_hit && !brk_q) begin
                                kb_d       = map_code;
                                kb_valid_d = 1'b1;
                            end
`ifdef PS2_DIR_RELEASE_CLEAR_EN
                            if (map_hit && brk_q && (map_code == kb_q)) begin
                                kb_d       = 4'b1111;
                                kb_valid_d = 1'b1;
                            end
`endif
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (to_cnt_q == TO_LAST) begin
            state_d     = ST_IDLE;
            to_cnt_d    = '0;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            clk_prev_q  <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            kb_q        <= 4'b1111;
            kb_valid_q  <= 1'b0;
            key_code_q  <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            clk_prev_q  <= clk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            kb_q        <= kb_d;
            kb_valid_q  <= kb_valid_d;
            key_code_q  <= key_code_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign kb        = kb_q;
    assign kb_valid  = kb_valid_q;
    assign key_code  = key_code_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// tb_ps2_dir_decoder
//   Drives PS/2 frames into ps2_dir_decoder (directed scenarios followed by
//   a random byte stream with occasional corrupted frames) and compares
//   kb, kb_valid pulse count, frame_err pulse count and key_code against a
//   table-driven key model.  Follows PS2_DIR_RELEASE_CLEAR_EN if defined.
module tb_ps2_dir_decoder;

    localparam int unsigned TO_CYC = 400;
    localparam int          HALF   = 10;

    logic       clk_50 = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] kb;
    logic       kb_valid;
    logic [7:0] key_code;
    logic       frame_err;

    ps2_dir_decoder #(
        .TIMEOUT_CYC (TO_CYC),
        .SYNC_STAGES (2)
    ) dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kb        (kb),
        .kb_valid  (kb_valid),
        .key_code  (key_code),
        .frame_err (frame_err)
    );

    always #10 clk_50 = ~clk_50;

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse monitor: cumulative high-cycle counts sampled on the falling edge.
    int tot_v    = 0;
    int tot_e    = 0;
    int tot_both = 0;
    always @(negedge clk_50) begin
        if (kb_valid)              tot_v++;
        if (frame_err)             tot_e++;
        if (kb_valid && frame_err) tot_both++;
    end

    // Key model state
    logic [3:0] m_kb;
    logic [7:0] m_key;
    bit         m_ext, m_brk;
    int         exp_v, exp_e;
    logic [7:0] mk_plain [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    logic [7:0] mk_ext   [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] pool     [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B,
                                  8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic model_reset();
        m_kb = 4'b1111; m_key = 8'h00; m_ext = 0; m_brk = 0;
    endtask

    // Expected effect of one complete frame (ok = parity and stop both good).
    task automatic model_frame(input logic [7:0] b, input bit ok);
        int idx;
        exp_v = 0;
        exp_e = 0;
        if (!ok) begin
            exp_e = 1; m_ext = 0; m_brk = 0;
        end else begin
            m_key = b;
            if (b == 8'hE0)      m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else begin
                idx = -1;
                for (int i = 0; i < 4; i++)
                    if ((m_ext ? mk_ext[i] : mk_plain[i]) == b) idx = i;
                if (idx >= 0) begin
                    if (!m_brk) begin
                        m_kb = 4'(idx); exp_v = 1;
                    end
`ifdef PS2_DIR_RELEASE_CLEAR_EN
                    else if (m_kb == 4'(idx)) begin
                        m_kb = 4'b1111; exp_v = 1;
                    end
`endif
                end
                m_ext = 0; m_brk = 0;
            end
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int v0, e0;
        v0 = tot_v;
        e0 = tot_e;
        model_frame(b, !(bad_par || bad_stop));
        send_bits(b, bad_par, bad_stop, 11);
        wait_cyc(12);
        check("kb_valid_pulses", tot_v - v0, exp_v);
        check("frame_err_pulses", tot_e - e0, exp_e);
        check("kb", kb, m_kb);
        check("key_code", key_code, m_key);
    endtask

    initial begin
        int v0, e0, sel;
        logic [7:0] b;
        bit bp, bs;

        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        wait_cyc(5);
        check("rst_kb", kb, 4'b1111);
        check("rst_kb_valid", kb_valid, 1'b0);
        check("rst_key_code", key_code, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Extended arrow
        do_frame(8'hE0, 0, 0);
        do_frame(8'h75, 0, 0);

        // WASD make then break
        rst_n = 1'b0; wait_cyc(3); rst_n = 1'b1; model_reset(); wait_cyc(3);
        do_frame(8'h1C, 0, 0);
        do_frame(8'hF0, 0, 0);
        do_frame(8'h1C, 0, 0);

        // Corrupted parity and stop after a fresh reset
        rst_n = 1'b0; wait_cyc(3); rst_n = 1'b1; model_reset(); wait_cyc(3);
        do_frame(8'h23, 1, 0);
        do_frame(8'h23, 0, 1);

        // Timeout of a partial frame after E0; ext must be dropped
        do_frame(8'hE0, 0, 0);
        v0 = tot_v; e0 = tot_e;
        send_bits(8'h75, 0, 0, 5);
        wait_cyc(TO_CYC + 50);
        m_ext = 0; m_brk = 0;
        check("timeout_err_pulses", tot_e - e0, 1);
        check("timeout_no_valid", tot_v - v0, 0);
        check("timeout_kb", kb, m_kb);
        do_frame(8'h1D, 0, 0);

        // Arrow code without E0 is ignored, with E0 accepted
        do_frame(8'h74, 0, 0);
        do_frame(8'hE0, 0, 0);
        do_frame(8'h74, 0, 0);

        // Reset mid-frame after E0
        do_frame(8'hE0, 0, 0);
        send_bits(8'h72, 0, 0, 4);
        rst_n = 1'b0;
        wait_cyc(3);
        check("midrst_kb", kb, 4'b1111);
        check("midrst_kb_valid", kb_valid, 1'b0);
        check("midrst_key_code", key_code, 8'h00);
        check("midrst_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        model_reset();
        wait_cyc(3);
        do_frame(8'h72, 0, 0);

        // Random byte stream with occasional framing faults
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 11);
            b   = (sel < 10) ? pool[sel] : 8'($urandom);
            sel = $urandom_range(0, 15);
            bp  = (sel == 0);
            bs  = (sel == 1);
            do_frame(b, bp, bs);
        end

        check("valid_err_overlap", tot_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_dir_decoder.md
Name: ps2_dir_decoder

Overview:
- Receives PS/2 keyboard frames and converts arrow/WASD scan codes into the 4-bit direction code consumed by the game core's `kb` input.
- Sits between the board PS/2 pins and the snake game block, in the clk_50 domain.
- Direction codes: 4'b0000 up, 4'b0001 down, 4'b0010 left, 4'b0011 right, 4'b1111 no move.
- Also reports framing errors and the last raw byte received.

Parameters:
- TIMEOUT_CYC, 50000: clk_50 cycles with no PS/2 clock falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- SYNC_STAGES, 2: number of flip-flop stages synchronising ps2_clk and ps2_data (minimum 2).

Ports:
- clk_50  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- ps2_clk  in  1  PS/2 clock pin, asynchronous to clk_50.
- ps2_data  in  1  PS/2 data pin, asynchronous to clk_50.
- kb  out  4  current direction code, held until changed.
- kb_valid  out  1  one-cycle pulse when kb is written.
- key_code  out  8  last byte received with good framing, including E0/F0.
- frame_err  out  1  one-cycle pulse on a bad frame or a timeout.

Behaviour:
- Reset (async, rst_n=0): kb=4'b1111, kb_valid=0, key_code=8'h00, frame_err=0, FSM=IDLE, ext=0, brk=0, timeout counter=0. Asserting rst_n mid-frame discards the partial frame.
- Input sampling: ps2_clk and ps2_data pass through SYNC_STAGES flip-flops each. A falling edge is synced clk of 1 followed by 0. ps2_data is sampled only in the cycle a falling edge is detected.
- Frame format: 11 bits — start(0), 8 data bits LSB first, odd parity, stop(1).
- FSM states and transitions, all on falling edges:
  - IDLE -> DATA when a start bit is sampled as 0. A start bit sampled as 1 keeps IDLE with no error.
  - DATA: shift in 8 bits, bit counter 0..7. DATA -> PARITY after bit 7.
  - PARITY -> STOP after sampling the parity bit.
  - STOP -> IDLE after sampling the stop bit.
- Frame check at the stop-bit sample:
  - Good: the XOR of 8 data bits and the parity bit equals 1, and stop=1.
  - Bad: frame_err pulses for 1 cycle; the byte is discarded; ext and brk are cleared; key_code is unchanged.
- Timeout: in any state other than IDLE, the counter increments each cycle and clears on every falling edge. When it reaches TIMEOUT_CYC-1: FSM -> IDLE, frame_err pulses, ext and brk are cleared.
- Good byte handling (key_code updated to the byte in every case):
  - 8'hE0 -> set ext. 8'hF0 -> set brk. These do not touch kb.
  - Any other byte is looked up, then ext and brk are cleared.
  - Make codes (brk=0):
    - ext=1: 75 -> 0000, 72 -> 0001, 6B -> 0010, 74 -> 0011.
    - ext=0: 1D(W) -> 0000, 1B(S) -> 0001, 1C(A) -> 0010, 23(D) -> 0011.
  - A mapped make writes kb and pulses kb_valid, even when the new code equals the old one (typematic repeat).
  - Unmapped bytes, and 75/72/6B/74 arriving without E0, are ignored: no kb change, no kb_valid.
  - Break codes (brk=1) of mapped keys: no kb change (see the optional feature).
- Latency: kb, kb_valid and frame_err are registered and change on the clk_50 cycle after the cycle in which the stop bit is sampled.
- kb_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: PS2_DIR_RELEASE_CLEAR_EN.
- Defined: a break of the mapped key whose code currently equals kb sets kb=4'b1111 and pulses kb_valid. A break of any other key is ignored.
- Undefined: breaks never modify kb, so the last direction persists. This is the default for the game, because the snake keeps moving.

Test Plan:
- Frame E0, then 75, good parity -> kb=4'b0000, one kb_valid pulse, key_code=8'h75.
- Frame 1C after a reset -> kb=4'b0010, kb_valid pulse. Then frames F0, 1C -> kb stays 4'b0010 with no kb_valid (macro off); with the macro on -> kb=4'b1111 and a kb_valid pulse.
- Frame 23 with a corrupted parity bit -> frame_err pulses once, kb stays 4'b1111, key_code unchanged.
- 5 bits of a frame, then ps2_clk held high for TIMEOUT_CYC cycles -> frame_err pulse, FSM back in IDLE. The next clean frame 1D -> kb=4'b0000.
- Frame 74 without a preceding E0 -> no kb_valid, kb unchanged. Frames E0, 74 -> kb=4'b0011.
- rst_n pulled low mid-frame after E0 has been received -> all outputs at reset values. Then frame 72 alone -> ignored, because ext was cleared by reset.
